// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: FSM state type, pixel width and palette for the colour generator.
package ws2812_pkg;

  localparam int unsigned PIX_W = 24;

  typedef enum logic [2:0] {StIdle, StFetch, StHigh, StLow, StLatch} state_e;

  // Colours are {G,R,B}, the order the LEDs expect on the wire.
  localparam logic [PIX_W-1:0] RED    = 24'h00FF00;
  localparam logic [PIX_W-1:0] ORANGE = 24'h80FF00;
  localparam logic [PIX_W-1:0] YELLOW = 24'hFFFF00;
  localparam logic [PIX_W-1:0] GREEN  = 24'hFF0000;
  localparam logic [PIX_W-1:0] BLUE   = 24'h0000FF;
  localparam logic [PIX_W-1:0] PURPLE = 24'h00FFFF;
  localparam logic [PIX_W-1:0] BLANK  = 24'h000000;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_pixel_buf.sv
// One-entry holding register between the pixel source and the shift register.
module ws2812_pixel_buf
  import ws2812_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [PIX_W-1:0] data
);

  // A push in the same cycle as a pop refills the entry, so push wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ws2812_frame_driver.sv
// WS2812B frame driver: serialises NUM_PIXELS colours onto dout, then holds the latch gap.
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = 64,
  parameter int unsigned T0H_CYC    = 16,
  parameter int unsigned T1H_CYC    = 32,
  parameter int unsigned T0L_CYC    = 34,
  parameter int unsigned T1L_CYC    = 18,
  parameter int unsigned RES_CYC    = 2000,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic                                                  pix_valid,
  input  logic [PIX_W-1:0]                                      pix_data,
  output logic                                                  pix_ready,
  output logic                                                  dout,
  output logic                                                  busy,
  output logic [((NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1)-1:0] pix_index,
  output logic                                                  frame_done,
  output logic                                                  underrun
);

  localparam int unsigned IdxW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int unsigned CntW =
      $clog2(max_of(max_of(max_of(T0H_CYC, T1H_CYC), max_of(T0L_CYC, T1L_CYC)), RES_CYC) + 1);

  // Phase counter load values: a phase of N cycles loads N-1 and ends at zero.
  localparam logic [CntW-1:0] HiLd0      = CntW'(T0H_CYC - 1);
  localparam logic [CntW-1:0] HiLd1      = CntW'(T1H_CYC - 1);
  localparam logic [CntW-1:0] LoLd0      = CntW'(T0L_CYC - 1);
  localparam logic [CntW-1:0] LoLd1      = CntW'(T1L_CYC - 1);
  localparam logic [CntW-1:0] LoFetchLd0 = CntW'(T0L_CYC - 2);
  localparam logic [CntW-1:0] LoFetchLd1 = CntW'(T1L_CYC - 2);
  localparam logic [CntW-1:0] ResLd      = CntW'(RES_CYC - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [4:0]       bit_q;
  logic [PIX_W-1:0] shift_q;

  logic             buf_full;
  logic [PIX_W-1:0] buf_data;
  logic             push;
  logic             pop;
  logic [PIX_W-1:0] fetch_word;
  logic [PIX_W-1:0] shift_next;
  logic             cur_bit;
  logic             fetch_bit;
  logic             next_bit;
  logic             last_bit;
  logic             last_pix;

  assign pix_ready  = ~buf_full & (state_q != StLatch) & ~reset;
  assign push       = pix_valid & pix_ready;
  assign pop        = (state_q == StFetch);
  assign busy       = (state_q != StIdle);

  // An empty buffer at fetch time sends a black pixel rather than stalling the frame.
  assign fetch_word = buf_full ? buf_data : '0;
  assign shift_next = MSB_FIRST ? {shift_q[PIX_W-2:0], 1'b0} : {1'b0, shift_q[PIX_W-1:1]};
  assign cur_bit    = MSB_FIRST ? shift_q[PIX_W-1] : shift_q[0];
  assign fetch_bit  = MSB_FIRST ? fetch_word[PIX_W-1] : fetch_word[0];
  assign next_bit   = MSB_FIRST ? shift_next[PIX_W-1] : shift_next[0];
  assign last_bit   = (bit_q == 5'(PIX_W - 1));
  assign last_pix   = (pix_index == IdxW'(NUM_PIXELS - 1));

  ws2812_pixel_buf u_pixel_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(pix_data),
    .pop      (pop),
    .full     (buf_full),
    .data     (buf_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pix_index  <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StFetch;
            underrun  <= 1'b0;
            pix_index <= '0;
          end
        end
        StFetch: begin
          shift_q <= fetch_word;
          bit_q   <= '0;
          if (!buf_full) underrun <= 1'b1;
          cnt_q   <= fetch_bit ? HiLd1 : HiLd0;
          dout    <= 1'b1;
          state_q <= StHigh;
        end
        StHigh: begin
          if (cnt_q == '0) begin
            dout    <= 1'b0;
            state_q <= StLow;
            // The following fetch cycle is part of this bit's low time.
            if (last_bit && !last_pix) cnt_q <= cur_bit ? LoFetchLd1 : LoFetchLd0;
            else                       cnt_q <= cur_bit ? LoLd1 : LoLd0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StLow: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!last_bit) begin
            shift_q <= shift_next;
            bit_q   <= bit_q + 5'd1;
            cnt_q   <= next_bit ? HiLd1 : HiLd0;
            dout    <= 1'b1;
            state_q <= StHigh;
          end else if (!last_pix) begin
            pix_index <= pix_index + IdxW'(1);
            state_q   <= StFetch;
          end else begin
            cnt_q      <= ResLd;
            frame_done <= (RES_CYC == 1);
            state_q    <= StLatch;
          end
        end
        StLatch: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) frame_done <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench: an MSB-first 2-pixel driver and an LSB-first 4-pixel driver, bit widths measured.
module tb_ws2812_frame_driver;

  logic clk;
  logic reset_a, reset_b;
  logic start_a, start_b;
  logic pix_valid_a, pix_valid_b;
  logic [23:0] pix_data_a, pix_data_b;
  logic pix_ready_a, pix_ready_b;
  logic dout_a, dout_b;
  logic busy_a, busy_b;
  logic [0:0] pix_index_a;
  logic [1:0] pix_index_b;
  logic frame_done_a, frame_done_b;
  logic underrun_a, underrun_b;

  logic [23:0] pat_a [16];
  logic [23:0] pat_b [8];
  int xfer_a = 0;
  int xfer_b = 0;
  int lim_a, lim_b;
  int frames_a = 0;
  int frames_b = 0;

  int n_checks = 0;
  int n_errors = 0;

  int hi_w [96];
  int lo_w [96];
  int nbits, done_cnt, tail, tail_ready, idx_max;
  logic [23:0] exp_px [4];

  assign pix_valid_a = (xfer_a < lim_a);
  assign pix_valid_b = (xfer_b < lim_b);
  assign pix_data_a  = pat_a[xfer_a % 16];
  assign pix_data_b  = pat_b[xfer_b % 8];

  ws2812_frame_driver #(
    .NUM_PIXELS(2), .T0H_CYC(16), .T1H_CYC(32), .T0L_CYC(34), .T1L_CYC(18),
    .RES_CYC(2000), .MSB_FIRST(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .pix_valid(pix_valid_a),
    .pix_data(pix_data_a), .pix_ready(pix_ready_a), .dout(dout_a), .busy(busy_a),
    .pix_index(pix_index_a), .frame_done(frame_done_a), .underrun(underrun_a)
  );

  ws2812_frame_driver #(
    .NUM_PIXELS(4), .T0H_CYC(16), .T1H_CYC(32), .T0L_CYC(34), .T1L_CYC(18),
    .RES_CYC(100), .MSB_FIRST(1'b0)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .pix_valid(pix_valid_b),
    .pix_data(pix_data_b), .pix_ready(pix_ready_b), .dout(dout_b), .busy(busy_b),
    .pix_index(pix_index_b), .frame_done(frame_done_b), .underrun(underrun_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pix_valid_a && pix_ready_a) xfer_a <= xfer_a + 1;
    if (pix_valid_b && pix_ready_b) xfer_b <= xfer_b + 1;
    if (frame_done_a) frames_a <= frames_a + 1;
    if (frame_done_b) frames_b <= frames_b + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v;
    else            start_b = v;
  endtask

  // Offer two pixels to driver A; they preload/prefetch through the buffer.
  task automatic supply_a(input logic [23:0] p0, input logic [23:0] p1);
    pat_a[xfer_a % 16]       = p0;
    pat_a[(xfer_a + 1) % 16] = p1;
    lim_a     = xfer_a + 2;
    exp_px[0] = p0;
    exp_px[1] = p1;
    repeat (2) @(negedge clk);
  endtask

  // Start a frame and record high/low run lengths of dout until busy falls.
  task automatic capture(input int which, input int poke, input int total);
    logic prev, s, bz, fd, rd;
    int run, cyc, idx;
    nbits = 0; done_cnt = 0; tail = 0; tail_ready = 0; idx_max = 0;
    run = 0; cyc = 0; prev = 1'b0; bz = 1'b1;
    @(negedge clk); set_start(which, 1'b1);
    @(negedge clk); set_start(which, 1'b0);
    while (cyc < 20000) begin
      s   = (which == 0) ? dout_a : dout_b;
      bz  = (which == 0) ? busy_a : busy_b;
      fd  = (which == 0) ? frame_done_a : frame_done_b;
      rd  = (which == 0) ? pix_ready_a : pix_ready_b;
      idx = (which == 0) ? int'(pix_index_a) : int'(pix_index_b);
      if (!bz) break;
      if (idx > idx_max) idx_max = idx;
      if (fd) begin
        done_cnt++;
        if (poke != 0) set_start(which, 1'b1);
      end
      if (poke != 0 && nbits == 10 && s) set_start(which, 1'b1);
      if (s != prev) begin
        if (prev) begin
          if (nbits < 96) hi_w[nbits] = run;
          nbits++;
        end else if (nbits > 0 && nbits <= 96) begin
          lo_w[nbits-1] = run;
        end
        run  = 1;
        prev = s;
      end else begin
        run++;
      end
      if (nbits == total && !s && rd) tail_ready++;
      @(negedge clk);
      set_start(which, 1'b0);
      cyc++;
    end
    tail = run;
    set_start(which, 1'b0);
    check_eq("frame_ended", int'(bz), 0);
  endtask

  task automatic check_frame(input int which, input int npix, input bit drained, input int res);
    logic [23:0] d;
    logic b;
    int k, tl;
    tl = 0;
    check_eq("bit_count", nbits, npix * 24);
    check_eq("frame_done_pulses", done_cnt, 1);
    check_eq("last_pix_index", idx_max, npix - 1);
    for (int p = 0; p < npix; p++) begin
      d = exp_px[p];
      for (int i = 0; i < 24; i++) begin
        b  = (which == 0) ? d[23-i] : d[i];
        k  = p * 24 + i;
        tl = b ? 18 : 34;
        check_eq($sformatf("high_cycles[%0d]", k), hi_w[k], b ? 32 : 16);
        if (k < npix * 24 - 1) check_eq($sformatf("low_cycles[%0d]", k), lo_w[k], tl);
      end
    end
    check_eq("tail_low", tail, tl + res);
    check_eq("ready_in_tail", tail_ready, drained ? tl : 0);
  endtask

  initial begin
    int cyc;
    int xb0;
    reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    lim_a = 0; lim_b = 1000;
    pat_b[0] = 24'h000001; pat_b[1] = 24'h800000; pat_b[2] = 24'h0000F0; pat_b[3] = 24'hA5A5A5;
    pat_b[4] = 24'h123456; pat_b[5] = 24'hFEDCBA; pat_b[6] = 24'h00FF00; pat_b[7] = 24'h0F0F0F;
    for (int i = 0; i < 16; i++) pat_a[i] = 24'h0;
    repeat (3) @(negedge clk);

    check_eq("rst_dout", int'(dout_a), 0);
    check_eq("rst_busy", int'(busy_a), 0);
    check_eq("rst_pix_ready", int'(pix_ready_a), 0);
    check_eq("rst_pix_ready_b", int'(pix_ready_b), 0);
    check_eq("rst_frame_done", int'(frame_done_a), 0);
    check_eq("rst_underrun", int'(underrun_a), 0);
    check_eq("rst_pix_index", int'(pix_index_a), 0);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", int'(pix_ready_a), 1);

    // Preloaded pixels, MSB first.
    supply_a(24'h800001, 24'h000000);
    capture(0, 0, 48);
    check_frame(0, 2, 1'b1, 2000);
    check_eq("t1_underrun", int'(underrun_a), 0);
    check_eq("t1_transfers", xfer_a, lim_a);

    // No data at all: black frame, sticky underrun until the next start.
    exp_px[0] = 24'h0; exp_px[1] = 24'h0;
    capture(0, 0, 48);
    check_frame(0, 2, 1'b1, 2000);
    check_eq("t3_underrun_set", int'(underrun_a), 1);
    supply_a(24'hFFFFFF, 24'h5A0F3C);
    check_eq("t3_underrun_sticky", int'(underrun_a), 1);
    capture(0, 0, 48);
    check_frame(0, 2, 1'b1, 2000);
    check_eq("t3_underrun_cleared", int'(underrun_a), 0);

    // Start pulses mid-frame and in the frame_done cycle must be ignored.
    supply_a(24'h123456, 24'h00FF00);
    capture(0, 1, 48);
    check_frame(0, 2, 1'b1, 2000);
    repeat (5) @(negedge clk);
    check_eq("t6_no_restart", int'(busy_a), 0);

    // Reset during the high phase of pixel 1.
    supply_a(24'hC0FFEE, 24'h0F0F0F);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    cyc = 0;
    while (!(pix_index_a == 1'b1 && dout_a) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t5_reached_pix1_high", int'(dout_a), 1);
    #2 reset_a = 1'b1;
    #1;
    check_eq("t5_async_dout", int'(dout_a), 0);
    check_eq("t5_async_busy", int'(busy_a), 0);
    check_eq("t5_async_index", int'(pix_index_a), 0);
    @(negedge clk);
    reset_a = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("t5_idle_after_reset", int'(busy_a), 0);
    supply_a(24'h00AA55, 24'h81C3E7);
    capture(0, 0, 48);
    check_frame(0, 2, 1'b1, 2000);
    repeat (3) @(negedge clk);
    check_eq("frames_a", frames_a, 5);

    // LSB-first, 4 pixels, source always valid.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 4; p++) exp_px[p] = pat_b[f * 4 + p];
      xb0 = xfer_b;
      capture(1, 0, 96);
      check_frame(1, 4, 1'b0, 100);
      check_eq($sformatf("b_transfers_frame%0d", f), xfer_b - xb0, 4);
      check_eq($sformatf("b_underrun_frame%0d", f), int'(underrun_b), 0);
    end
    repeat (3) @(negedge clk);
    check_eq("frames_b", frames_b, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
